// File: rtl/lsu_ctrl.sv
// Load/store unit controller between the EXU/WBU pipeline and a single-port data-memory bus.
// Allows one outstanding access. Builds byte enables and lane-shifted store data, and
// aligns plus sign- or zero-extends load data. Misaligned or illegal accesses and bus
// timeouts are reported in rsp_err rather than issued or left hanging.
// Optional build macro LSU_TRACE_EN: adds a 64-bit cycle counter and prints one line per
// response handshake.
module lsu_ctrl #(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned AW      = 64,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [AW-1:0]     req_addr,
   input  logic [2:0]        req_type,
   input  logic              req_wen,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [XLEN-1:0]   rsp_rdata,
   output logic [1:0]        rsp_err,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [AW-1:0]     mem_addr,
   output logic              mem_wen,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN/8-1:0] mem_wmask,
   input  logic              mem_rsp_valid,
   input  logic [XLEN-1:0]   mem_rsp_rdata
);

   localparam int unsigned NB = XLEN / 8;
   localparam int unsigned OW = $clog2(NB);
   localparam int unsigned SW = $clog2(XLEN);
   // The counter only has to reach TIMEOUT-1; the threshold fires on the following edge.
   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

   state_e          state;
   logic [CW-1:0]   cnt;
   logic [OW-1:0]   off_q;
   logic [1:0]      size_q;
   logic            uns_q;

   logic [OW-1:0]   req_off;
   logic [1:0]      req_size;
   logic [3:0]      align_mask;
   logic            req_bad;
   logic [NB-1:0]   lane_bits;
   logic [NB-1:0]   req_mask;
   logic [XLEN-1:0] req_wdata_sh;

   logic [XLEN-1:0] load_sh;
   int unsigned     load_bits;
   logic [SW-1:0]   sign_idx;
   logic            sign_bit;
   logic [XLEN-1:0] load_data;

   // Request decode: lane offset, byte enables, lane-shifted store data and legality.
   always_comb begin
      req_off    = req_addr[OW-1:0];
      req_size   = req_type[1:0];
      align_mask = (4'd1 << req_size) - 4'd1;
      req_bad    = (|(req_addr[2:0] & align_mask[2:0])) || ((XLEN == 32) && (req_size == 2'd3));
      lane_bits  = '0;
      unique case (req_size)
         2'd0:    lane_bits = NB'(8'h01);
         2'd1:    lane_bits = NB'(8'h03);
         2'd2:    lane_bits = NB'(8'h0F);
         default: lane_bits = NB'(8'hFF);
      endcase
      req_mask     = lane_bits << req_off;
      req_wdata_sh = req_wdata << {req_off, 3'b000};
   end

   // Load alignment: shift the addressed lanes down, then sign- or zero-extend the slice.
   always_comb begin
      load_sh   = mem_rsp_rdata >> {off_q, 3'b000};
      load_bits = 32'd8 << size_q;
      if (load_bits > XLEN) begin
         load_bits = XLEN;
      end
      sign_idx  = SW'(load_bits - 32'd1);
      sign_bit  = load_sh[sign_idx] & ~uns_q;
      load_data = '0;
      for (int unsigned i = 0; i < XLEN; i++) begin
         load_data[i] = (i < load_bits) ? load_sh[i] : sign_bit;
      end
   end

   // Access FSM; every port output is a register updated here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= StIdle;
         cnt           <= '0;
         off_q         <= '0;
         size_q        <= '0;
         uns_q         <= 1'b0;
         req_ready     <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_err       <= 2'b00;
         mem_req_valid <= 1'b0;
         mem_addr      <= '0;
         mem_wen       <= 1'b0;
         mem_wdata     <= '0;
         mem_wmask     <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  off_q     <= req_off;
                  size_q    <= req_size;
                  uns_q     <= req_type[2];
                  mem_wen   <= req_wen;
                  mem_addr  <= {req_addr[AW-1:OW], {OW{1'b0}}};
                  mem_wdata <= req_wdata_sh;
                  mem_wmask <= req_mask;
                  if (req_bad) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 2'b01;
                     rsp_rdata <= '0;
                     state     <= StResp;
                  end else begin
                     mem_req_valid <= 1'b1;
                     state         <= StReq;
                  end
               end
            end
            StReq: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  cnt           <= '0;
                  state         <= StWait;
               end
            end
            StWait: begin
               // A response arriving on the threshold cycle takes priority over the timeout.
               if (mem_rsp_valid) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 2'b00;
                  rsp_rdata <= mem_wen ? '0 : load_data;
                  state     <= StResp;
               end else if ((TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1))) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 2'b10;
                  rsp_rdata <= '0;
                  state     <= StResp;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            StResp: begin
               // Returning to idle with req_ready set forbids a same-cycle new request.
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

`ifdef LSU_TRACE_EN
   logic [63:0] cycle_cnt;

   // Free-running cycle counter for trace timestamps.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 64'd1;
      end
   end

   // Print one line per completed response.
   always_ff @(posedge clk) begin
      if (rst && rsp_valid && rsp_ready) begin
         $display("[LSU] cyc=%0d %s addr=0x%0h size=%0d mask=0x%0h data=0x%0h err=%0d",
                  cycle_cnt, mem_wen ? "ST" : "LD", mem_addr + AW'(off_q), size_q,
                  mem_wmask, mem_wen ? mem_wdata : rsp_rdata, rsp_err);
      end
   end
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl (XLEN=64, AW=64, TIMEOUT=4). Inputs change and outputs are
// sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic [2:0]  req_type;
   logic        req_wen;
   logic [63:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_rdata;
   logic [1:0]  rsp_err;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [63:0] mem_addr;
   logic        mem_wen;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic        mem_rsp_valid;
   logic [63:0] mem_rsp_rdata;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   lsu_ctrl #(
      .XLEN    (64),
      .AW      (64),
      .TIMEOUT (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .req_type      (req_type),
      .req_wen       (req_wen),
      .req_wdata     (req_wdata),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_rdata     (rsp_rdata),
      .rsp_err       (rsp_err),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_addr      (mem_addr),
      .mem_wen       (mem_wen),
      .mem_wdata     (mem_wdata),
      .mem_wmask     (mem_wmask),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_rdata (mem_rsp_rdata)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Present a request for one rising edge; returns at the falling edge after the handshake.
   task automatic issue(input logic [63:0] addr, input logic [2:0] typ, input logic wen,
                        input logic [63:0] wd);
      req_valid = 1'b1;
      req_addr  = addr;
      req_type  = typ;
      req_wen   = wen;
      req_wdata = wd;
      ticks(1);
      req_valid = 1'b0;
   endtask

   initial begin
      rst           = 1'b0;
      req_valid     = 1'b0;
      req_addr      = '0;
      req_type      = '0;
      req_wen       = 1'b0;
      req_wdata     = '0;
      rsp_ready     = 1'b0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = '0;

      // Reset state
      #3;
      check("rst req_ready", req_ready, 0);
      check("rst rsp_valid", rsp_valid, 0);
      check("rst mem_req_valid", mem_req_valid, 0);
      ticks(2);
      check("rst held req_ready", req_ready, 0);
      rst = 1'b1;
      ticks(1);
      check("post-rst req_ready", req_ready, 1);

      // Signed word load at 0x8000_0004, minimum latency
      issue(64'h8000_0004, 3'b010, 1'b0, 64'h0);
      check("ldw mem_req_valid", mem_req_valid, 1);
      check("ldw mem_addr", mem_addr, 64'h8000_0000);
      check("ldw mem_wmask", mem_wmask, 8'hF0);
      check("ldw mem_wen", mem_wen, 0);
      check("ldw req_ready busy", req_ready, 0);
      mem_req_ready = 1'b1;
      ticks(1);
      mem_req_ready = 1'b0;
      check("ldw req dropped", mem_req_valid, 0);
      check("ldw no early rsp", rsp_valid, 0);
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = 64'h8765_4321_0000_0000;
      ticks(1);
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = '0;
      check("ldw rsp_valid", rsp_valid, 1);
      check("ldw rsp_rdata", rsp_rdata, 64'hFFFF_FFFF_8765_4321);
      check("ldw rsp_err", rsp_err, 2'b00);
      rsp_ready = 1'b1;
      ticks(1);
      rsp_ready = 1'b0;
      check("ldw rsp done", rsp_valid, 0);
      check("ldw idle ready", req_ready, 1);

      // Byte store at 0x8000_0003
      issue(64'h8000_0003, 3'b000, 1'b1, 64'hAB);
      check("stb mem_wmask", mem_wmask, 8'h08);
      check("stb mem_wdata", mem_wdata, 64'h0000_0000_AB00_0000);
      check("stb mem_wen", mem_wen, 1);
      check("stb mem_addr", mem_addr, 64'h8000_0000);
      mem_req_ready = 1'b1;
      ticks(1);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      ticks(1);
      mem_rsp_valid = 1'b0;
      check("stb rsp_valid", rsp_valid, 1);
      check("stb rsp_rdata", rsp_rdata, 64'h0);
      check("stb rsp_err", rsp_err, 2'b00);
      rsp_ready = 1'b1;
      ticks(1);
      rsp_ready = 1'b0;

      // Misaligned unsigned halfword load
      issue(64'h8000_0001, 3'b101, 1'b0, 64'h0);
      check("mis no bus req", mem_req_valid, 0);
      check("mis rsp_valid", rsp_valid, 1);
      check("mis rsp_err", rsp_err, 2'b01);
      check("mis rsp_rdata", rsp_rdata, 64'h0);
      rsp_ready = 1'b1;
      ticks(1);
      rsp_ready = 1'b0;
      check("mis still no bus req", mem_req_valid, 0);
      check("mis back idle", req_ready, 1);

      // Timeout after four WAIT cycles, late responses ignored
      issue(64'h8000_0010, 3'b010, 1'b0, 64'h0);
      mem_req_ready = 1'b1;
      ticks(1);
      mem_req_ready = 1'b0;
      ticks(3);
      check("tmo not yet", rsp_valid, 0);
      ticks(1);
      check("tmo rsp_valid", rsp_valid, 1);
      check("tmo rsp_err", rsp_err, 2'b10);
      check("tmo rsp_rdata", rsp_rdata, 64'h0);
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      ticks(1);
      mem_rsp_valid = 1'b0;
      check("tmo late rdata", rsp_rdata, 64'h0);
      check("tmo late err", rsp_err, 2'b10);
      rsp_ready = 1'b1;
      ticks(1);
      rsp_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      ticks(1);
      mem_rsp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("tmo no 2nd rsp", rsp_valid, 0);
         ticks(1);
      end
      check("tmo idle ready", req_ready, 1);

      // Bus stall 5 cycles, consumer stall 3 cycles; signed halfword at 0x8000_0006
      issue(64'h8000_0006, 3'b001, 1'b0, 64'h1234);
      req_addr  = 64'hFFFF_FFFF_FFFF_FFFF;
      req_wdata = 64'h5A5A_5A5A_5A5A_5A5A;
      for (int i = 0; i < 5; i++) begin
         check("stl mem_req_valid", mem_req_valid, 1);
         check("stl mem_addr", mem_addr, 64'h8000_0000);
         check("stl mem_wdata", mem_wdata, 64'h1234_0000_0000_0000);
         check("stl mem_wmask", mem_wmask, 8'hC0);
         check("stl req_ready", req_ready, 0);
         ticks(1);
      end
      mem_req_ready = 1'b1;
      ticks(1);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = 64'h8001_0000_0000_0000;
      ticks(1);
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = 64'h5555_5555_5555_5555;
      for (int i = 0; i < 3; i++) begin
         check("stl rsp_valid", rsp_valid, 1);
         check("stl rsp_rdata", rsp_rdata, 64'hFFFF_FFFF_FFFF_8001);
         check("stl rsp_err", rsp_err, 2'b00);
         check("stl rsp req_ready", req_ready, 0);
         ticks(1);
      end
      rsp_ready = 1'b1;
      ticks(1);
      rsp_ready = 1'b0;
      check("stl rsp done", rsp_valid, 0);
      check("stl idle ready", req_ready, 1);

      // Response on the timeout threshold cycle wins; no request bypass on rsp handshake
      issue(64'h8000_0005, 3'b000, 1'b0, 64'h0);
      check("race mem_wmask", mem_wmask, 8'h20);
      mem_req_ready = 1'b1;
      ticks(1);
      mem_req_ready = 1'b0;
      ticks(3);
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = 64'h0000_8000_0000_0000;
      ticks(1);
      mem_rsp_valid = 1'b0;
      check("race rsp_valid", rsp_valid, 1);
      check("race rsp_err", rsp_err, 2'b00);
      check("race rsp_rdata", rsp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_addr  = 64'h8000_0007;
      req_type  = 3'b100;
      req_wen   = 1'b0;
      ticks(1);
      check("nobyp mem_req_valid", mem_req_valid, 0);
      check("nobyp rsp_valid", rsp_valid, 0);
      check("nobyp req_ready", req_ready, 1);
      ticks(1);
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      check("nobyp accepted", mem_req_valid, 1);
      check("nobyp mem_wmask", mem_wmask, 8'h80);
      mem_req_ready = 1'b1;
      ticks(1);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = 64'hFF00_0000_0000_0000;
      ticks(1);
      mem_rsp_valid = 1'b0;
      check("lbu rsp_rdata", rsp_rdata, 64'h0000_0000_0000_00FF);
      check("lbu rsp_err", rsp_err, 2'b00);
      rsp_ready = 1'b1;
      ticks(1);
      rsp_ready = 1'b0;

      // Reset during WAIT clears outputs without a clock edge
      issue(64'h8000_0020, 3'b010, 1'b0, 64'hCAFE);
      check("rw mem_addr", mem_addr, 64'h8000_0020);
      mem_req_ready = 1'b1;
      ticks(1);
      mem_req_ready = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check("rw mem_addr 0", mem_addr, 64'h0);
      check("rw mem_wdata 0", mem_wdata, 64'h0);
      check("rw mem_wmask 0", mem_wmask, 8'h00);
      check("rw rsp_rdata 0", rsp_rdata, 64'h0);
      check("rw rsp_err 0", rsp_err, 2'b00);
      check("rw req_ready 0", req_ready, 0);
      check("rw rsp_valid 0", rsp_valid, 0);
      ticks(1);
      rst = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = 64'h1111_2222_3333_4444;
      ticks(1);
      mem_rsp_valid = 1'b0;
      check("rw dropped rsp", rsp_valid, 0);
      check("rw ready again", req_ready, 1);
      issue(64'h8000_0008, 3'b011, 1'b0, 64'h0);
      check("ldd mem_addr", mem_addr, 64'h8000_0008);
      check("ldd mem_wmask", mem_wmask, 8'hFF);
      mem_req_ready = 1'b1;
      ticks(1);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = 64'h0123_4567_89AB_CDEF;
      ticks(1);
      mem_rsp_valid = 1'b0;
      check("ldd rsp_valid", rsp_valid, 1);
      check("ldd rsp_rdata", rsp_rdata, 64'h0123_4567_89AB_CDEF);
      check("ldd rsp_err", rsp_err, 2'b00);
      rsp_ready = 1'b1;
      ticks(1);
      rsp_ready = 1'b0;
      check("ldd done", rsp_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Multi-cycle, parametrised load/store unit between the EXU/WBU pipeline and a generic single-port data-memory bus.
- Accepts one access per valid/ready handshake and generates the byte mask from access size and the low address bits.
- Places store data on byte lanes, and aligns and sign- or zero-extends load data.
- Reports misalignment and bus timeout instead of issuing or hanging; exactly one outstanding access.

Parameters:
- XLEN, 64, data width in bits; legal values 32 or 64; NB = XLEN/8 byte lanes.
- AW, 64, address width.
- TIMEOUT, 255, maximum cycles waiting for mem_rsp_valid before error; 0 disables timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  access request valid.
- req_ready  out  1  LSU can accept a request.
- req_addr  in  AW  byte address.
- req_type  in  3  [1:0] size (0=B, 1=H, 2=W, 3=D); [2] 1 = unsigned load.
- req_wen  in  1  1 = store, 0 = load.
- req_wdata  in  XLEN  store data, right-justified.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_rdata  out  XLEN  extended load data; 0 for stores or errors.
- rsp_err  out  2  00 ok, 01 misaligned/illegal size, 10 timeout.
- mem_req_valid  out  1  bus request valid.
- mem_req_ready  in  1  bus accepts request.
- mem_addr  out  AW  req_addr with low log2(NB) bits cleared.
- mem_wen  out  1  bus write.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_wmask  out  NB  byte enables.
- mem_rsp_valid  in  1  bus response / write acknowledge.
- mem_rsp_rdata  in  XLEN  bus read data, full word.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; every output register 0; req_ready=0 while rst low, 1 from first clock after release.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1.
  - On req_valid&&req_ready, latch addr/type/wen/wdata.
  - Misaligned (addr mod 2^size != 0) or size=3 with XLEN=32: go to RESP, rsp_err=01, no bus access.
  - Otherwise go to REQ.
- REQ: mem_req_valid=1, outputs stable until mem_req_ready; then go to WAIT and clear the timeout counter.
- WAIT: on mem_rsp_valid, register the result, go to RESP, rsp_err=00.
  - Counter increments each WAIT cycle; on reaching TIMEOUT (TIMEOUT!=0), go to RESP with rsp_err=10 and rsp_rdata=0.
  - A late mem_rsp_valid after timeout is ignored.
- RESP: rsp_valid=1 held with stable data until rsp_ready; then go to IDLE. req_ready=0 in REQ/WAIT/RESP.
- Minimum latency: request handshake at cycle 0, mem_req_valid at cycle 1; with mem_req_ready=1 and mem_rsp_valid at cycle 2, rsp_valid at cycle 3.
- Byte offset off = addr[log2(NB)-1:0].
- mem_wmask = ((1<<(1<<size))-1) << off, truncated to NB bits.
- mem_wdata = req_wdata << (8*off); unused lanes are don't-care but driven deterministically (shifted value).
- Load: raw = mem_rsp_rdata >> (8*off), low (8<<size) bits kept.
  - Sign-extend when type[2]=0; zero-extend when type[2]=1. Size 3 with XLEN=64 passes through unchanged.
- Stores: rsp_rdata=0; the write acknowledge is mem_rsp_valid.
- Simultaneous events:
  - mem_rsp_valid in the same cycle as the timeout threshold: the response wins, err=00.
  - rsp_ready held high: next req accepted no earlier than the cycle after rsp handshake (no bypass).
- Reset asserted mid-access: immediate return to IDLE, all outputs 0, in-flight response dropped.

Optional Feature:
- LSU_TRACE_EN defined: on each rsp handshake, $display prints cycle count, "LD"/"ST", address, size, mask, data and err. Cycle count is a 64-bit counter present only under this macro.
- Undefined: no trace logic or counter synthesised; behaviour otherwise identical.

Test Plan:
- XLEN=64, load word signed at addr 0x8000_0004, mem returns 0x8765_4321_0000_0000 -> mem_addr 0x8000_0000, mask 0xF0, rsp_rdata 0xFFFF_FFFF_8765_4321, err 00, rsp_valid 3 cycles after handshake.
- Store byte 0xAB at addr 0x8000_0003 -> mem_wmask 0x08, mem_wdata[31:24]=0xAB, mem_wen=1; after ack rsp_rdata=0, err 00.
- Load halfword unsigned at 0x8000_0001 -> no mem_req_valid ever, rsp_valid next cycle with err 01, rdata 0.
- TIMEOUT=4, mem_rsp_valid never asserted -> rsp err 10 after 4 WAIT cycles; a later mem_rsp_valid pulse produces no second rsp_valid.
- mem_req_ready low 5 cycles, rsp_ready low 3 cycles -> mem_addr/wdata/wmask and rsp_rdata stable throughout; req_ready stays 0 until RESP handshake.
- Drop rst during WAIT -> all outputs 0 asynchronously; after release a fresh load of doubleword at 0x8000_0008 completes normally.
